// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode: absorbs in-flight fetches after a
// stall, presents {pc, instr} to decode in order, and empties on flush.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int SKID  = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       fetch_valid_i,
  input  logic [31:0]                fetch_instr_i,
  input  logic [31:0]                fetch_pc_i,
  output logic                       fetch_stall_o,
  input  logic                       flush_i,
  output logic                       dec_valid_o,
  output logic [31:0]                dec_instr_o,
  output logic [31:0]                dec_pc_o,
  input  logic                       dec_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [63:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [63:0]   w_head;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = dec_valid_o & dec_ready_i & ~flush_i;
  assign w_push = fetch_valid_i & ~flush_i & (~w_full | w_pop);
  assign w_drop = fetch_valid_i & ~flush_i & w_full & ~w_pop;

  assign w_head        = r_mem[r_rd_ptr];
  assign dec_valid_o   = (r_count != '0);
  assign dec_instr_o   = dec_valid_o ? w_head[31:0]  : 32'h0;
  assign dec_pc_o      = dec_valid_o ? w_head[63:32] : 32'h0;
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
  assign fetch_stall_o = ((CW'(DEPTH) - r_count) <= CW'(SKID)) | flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; entries are only observed once count covers them.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {fetch_pc_i, fetch_instr_i};
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: a queue model predicts every
// delivered {pc, instr}, occupancy, stall and overflow.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int SKID  = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          fetch_valid_i;
  logic [31:0]   fetch_instr_i;
  logic [31:0]   fetch_pc_i;
  logic          fetch_stall_o;
  logic          flush_i;
  logic          dec_valid_o;
  logic [31:0]   dec_instr_o;
  logic [31:0]   dec_pc_o;
  logic          dec_ready_i;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  logic [63:0] sb[$];
  bit          m_overflow;
  int          checks = 0;
  int          passes = 0;

  fetch_decode_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i),
    .fetch_pc_i(fetch_pc_i), .fetch_stall_o(fetch_stall_o),
    .flush_i(flush_i),
    .dec_valid_o(dec_valid_o), .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o),
    .dec_ready_i(dec_ready_i), .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Predicts push/pop from the model, samples the head, clocks once, updates model.
  task automatic tick(output bit popped, output logic [63:0] exp_head,
                      output logic [63:0] act_head);
    bit mpop, mpush;
    mpop  = (sb.size() != 0) && dec_ready_i && !flush_i;
    mpush = fetch_valid_i && !flush_i && ((sb.size() < DEPTH) || mpop);
    popped   = mpop;
    exp_head = mpop ? sb[0] : 64'h0;
    act_head = {dec_pc_o, dec_instr_o};
    @(posedge clk_i);
    if (flush_i) begin
      sb.delete();
      m_overflow = 1'b0;
    end else begin
      if (mpop) sb.delete(0);
      if (mpush) sb.push_back({fetch_pc_i, fetch_instr_i});
      else if (fetch_valid_i) m_overflow = 1'b1;
    end
    #1;
  endtask

  task automatic set_in(input bit fv, input logic [31:0] pc, input logic [31:0] ins,
                        input bit rdy);
    fetch_valid_i = fv;
    fetch_pc_i    = pc;
    fetch_instr_i = ins;
    dec_ready_i   = rdy;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    flush_i = 1'b0;
    set_in(0, 32'h0, 32'h0, 0);
    #12;
    checks++;
    if ({dec_valid_o, count_o, fetch_stall_o, overflow_o} !== {1'b0, CW'(0), 1'b0, 1'b0})
      $display("[TB] FAIL reset_flags: valid=%b count=%0d stall=%b ovf=%b expected 0/0/0/0",
               dec_valid_o, count_o, fetch_stall_o, overflow_o);
    else passes++;
    checks++;
    if ({dec_pc_o, dec_instr_o} !== 64'h0)
      $display("[TB] FAIL reset_head: got %h expected 0", {dec_pc_o, dec_instr_o});
    else passes++;
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_stream3();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    bit popped;
    logic [63:0] e, a;
    int npops = 0;
    int maxcnt = 0;
    pcs = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    ins = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
    for (int i = 0; i < 8; i++) begin
      if (i < 3) set_in(1, pcs[i], ins[i], 1);
      else set_in(0, 32'h0, 32'h0, 1);
      if (i == 0) begin
        checks++;
        if (dec_valid_o !== 1'b0)
          $display("[TB] FAIL stream_valid_before: got %b expected 0", dec_valid_o);
        else passes++;
      end
      tick(popped, e, a);
      if (i == 0) begin
        checks++;
        if ({dec_valid_o, dec_pc_o, dec_instr_o} !== {1'b1, pcs[0], ins[0]})
          $display("[TB] FAIL stream_first_visible: got %b %h %h expected 1 %h %h",
                   dec_valid_o, dec_pc_o, dec_instr_o, pcs[0], ins[0]);
        else passes++;
      end
      if (popped) begin
        checks++;
        if (a !== {pcs[npops], ins[npops]})
          $display("[TB] FAIL stream_order: got %h expected %h", a, {pcs[npops], ins[npops]});
        else passes++;
        npops++;
      end
      if (int'(count_o) > maxcnt) maxcnt = int'(count_o);
    end
    checks++;
    if (npops != 3 || maxcnt > 1 || overflow_o !== 1'b0)
      $display("[TB] FAIL stream_summary: pops=%0d maxcount=%0d ovf=%b expected 3 <=1 0",
               npops, maxcnt, overflow_o);
    else passes++;
  endtask

  task automatic test_full_push_pop();
    bit popped;
    logic [63:0] e, a;
    logic [31:0] last_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'h8000_0000 + 32'(4*i), 32'hA000_0000 + 32'(i), 0);
      tick(popped, e, a);
    end
    checks++;
    if (count_o !== CW'(4) || fetch_stall_o !== 1'b1)
      $display("[TB] FAIL full_fill: count=%0d stall=%b expected 4 1", count_o, fetch_stall_o);
    else passes++;
    set_in(1, 32'h8000_0010, 32'hA000_0004, 1);
    tick(popped, e, a);
    checks++;
    if (!popped || a[63:32] !== 32'h8000_0000)
      $display("[TB] FAIL full_pushpop_head: got pc %h expected 80000000", a[63:32]);
    else passes++;
    checks++;
    if (count_o !== CW'(4) || dec_pc_o !== 32'h8000_0004 || overflow_o !== 1'b0)
      $display("[TB] FAIL full_pushpop_state: count=%0d pc=%h ovf=%b expected 4 80000004 0",
               count_o, dec_pc_o, overflow_o);
    else passes++;
    set_in(0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      tick(popped, e, a);
      if (popped) begin
        checks++;
        if (a !== e) $display("[TB] FAIL full_drain_order: got %h expected %h", a, e);
        else passes++;
        last_pc = a[63:32];
      end
    end
    checks++;
    if (last_pc !== 32'h8000_0010 || count_o !== CW'(0) || overflow_o !== 1'b0)
      $display("[TB] FAIL full_drain_end: last pc=%h count=%0d ovf=%b expected 80000010 0 0",
               last_pc, count_o, overflow_o);
    else passes++;
  endtask

  task automatic test_overflow();
    bit popped;
    logic [63:0] e, a;
    set_in(1, 32'h8000_0000, 32'hB000_0000, 0);
    tick(popped, e, a);
    checks++;
    if (fetch_stall_o !== 1'b0)
      $display("[TB] FAIL ovf_stall_at1: got %b expected 0", fetch_stall_o);
    else passes++;
    set_in(1, 32'h8000_0004, 32'hB000_0001, 0);
    tick(popped, e, a);
    checks++;
    if (count_o !== CW'(2) || fetch_stall_o !== 1'b1)
      $display("[TB] FAIL ovf_stall_at2: count=%0d stall=%b expected 2 1", count_o, fetch_stall_o);
    else passes++;
    for (int i = 2; i < 4; i++) begin
      set_in(1, 32'h8000_0000 + 32'(4*i), 32'hB000_0000 + 32'(i), 0);
      tick(popped, e, a);
    end
    checks++;
    if (count_o !== CW'(4) || overflow_o !== 1'b0)
      $display("[TB] FAIL ovf_full: count=%0d ovf=%b expected 4 0", count_o, overflow_o);
    else passes++;
    set_in(1, 32'h8000_00F0, 32'hBAD0_0000, 0);
    tick(popped, e, a);
    checks++;
    if (overflow_o !== 1'b1 || count_o !== CW'(4) || dec_pc_o !== 32'h8000_0000)
      $display("[TB] FAIL ovf_drop: ovf=%b count=%0d pc=%h expected 1 4 80000000",
               overflow_o, count_o, dec_pc_o);
    else passes++;
    set_in(0, 32'h0, 32'h0, 1);
    tick(popped, e, a);
    checks++;
    if (count_o !== CW'(3) || overflow_o !== 1'b1 || overflow_o !== m_overflow)
      $display("[TB] FAIL ovf_sticky: count=%0d ovf=%b expected 3 1", count_o, overflow_o);
    else passes++;
  endtask

  task automatic test_flush();
    bit popped;
    logic [63:0] e, a;
    set_in(1, 32'h8000_0100, 32'hC000_0000, 1);
    flush_i = 1'b1;
    tick(popped, e, a);
    flush_i = 1'b0;
    set_in(0, 32'h0, 32'h0, 0);
    #1;
    checks++;
    if ({dec_valid_o, count_o, overflow_o, fetch_stall_o} !== {1'b0, CW'(0), 1'b0, 1'b0})
      $display("[TB] FAIL flush_state: valid=%b count=%0d ovf=%b stall=%b expected 0 0 0 0",
               dec_valid_o, count_o, overflow_o, fetch_stall_o);
    else passes++;
    flush_i = 1'b1;
    #1;
    checks++;
    if (fetch_stall_o !== 1'b1)
      $display("[TB] FAIL flush_stall_empty: got %b expected 1", fetch_stall_o);
    else passes++;
    tick(popped, e, a);
    flush_i = 1'b0;
    #1;
  endtask

  task automatic test_wrap();
    bit popped;
    logic [63:0] e, a;
    int sent = 0;
    int got = 0;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      set_in((sent < 10) && !fetch_stall_o, 32'h8000_0000 + 32'(4*sent),
             32'hD000_0000 + 32'(sent), cyc[0]);
      if (fetch_valid_i) sent++;
      tick(popped, e, a);
      if (popped) begin
        checks++;
        if (a !== e || a[63:32] !== 32'h8000_0000 + 32'(4*got) ||
            a[31:0] !== 32'hD000_0000 + 32'(got))
          $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", got, a,
                   {32'h8000_0000 + 32'(4*got), 32'hD000_0000 + 32'(got)});
        else passes++;
        got++;
      end
    end
    set_in(0, 32'h0, 32'h0, 0);
    checks++;
    if (got != 10 || count_o !== CW'(0) || overflow_o !== 1'b0)
      $display("[TB] FAIL wrap_total: delivered=%0d count=%0d ovf=%b expected 10 0 0",
               got, count_o, overflow_o);
    else passes++;
  endtask

  task automatic test_async_reset();
    bit popped;
    logic [63:0] e, a;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h8000_0200 + 32'(4*i), 32'hE000_0000 + 32'(i), 0);
      tick(popped, e, a);
    end
    set_in(0, 32'h0, 32'h0, 0);
    checks++;
    if (count_o !== CW'(3))
      $display("[TB] FAIL areset_pre: count=%0d expected 3", count_o);
    else passes++;
    #2;
    rstn_i = 1'b0;
    #1;
    sb.delete();
    m_overflow = 1'b0;
    checks++;
    if ({dec_valid_o, count_o, dec_pc_o} !== {1'b0, CW'(0), 32'h0})
      $display("[TB] FAIL areset_immediate: valid=%b count=%0d pc=%h expected 0 0 0",
               dec_valid_o, count_o, dec_pc_o);
    else passes++;
    #1;
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    m_overflow = 1'b0;
    test_reset();
    test_stream3();
    test_full_push_pop();
    test_overflow();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Absorbs instructions that fetch delivers after decode stalls, which come from outstanding wishbone acks still in flight.
- Drives the fetch stall input, and presents instructions to decode in order together with their PCs.
- A flush empties the queue in one cycle, so fetch can restart from a redirected PC.

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- SKID, 2, number of free entries reserved for in-flight fetches; stall_o asserts when free entries <= SKID; must satisfy 1 <= SKID < DEPTH.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- fetch_valid_i  in  1  fetch presents an instruction this cycle.
- fetch_instr_i  in  32  instruction word.
- fetch_pc_i  in  32  PC of fetch_instr_i.
- fetch_stall_o  out  1  connects to the fetch stall input.
- flush_i  in  1  discard all queued and incoming instructions.
- dec_valid_o  out  1  head entry valid.
- dec_instr_o  out  32  head instruction; 0 when empty.
- dec_pc_o  out  32  head PC; 0 when empty.
- dec_ready_i  in  1  decode consumes the head this cycle.
- count_o  out  $clog2(DEPTH+1)  occupancy.
- overflow_o  out  1  sticky error: a push was dropped.

Behaviour:
- Storage: DEPTH x 64-bit register array holding {pc, instr}.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count is a separate register.
- Reset (async, rstn_i=0): rd_ptr=0, wr_ptr=0, count=0, overflow_o=0.
  - Resulting outputs: dec_valid_o=0, dec_instr_o=0, dec_pc_o=0, fetch_stall_o=0, count_o=0.
  - Array contents are don't-care.
  - Reset mid-operation discards everything immediately.
- pop = dec_valid_o & dec_ready_i & !flush_i.
- push = fetch_valid_i & !flush_i & (count<DEPTH | pop).
  - When full, a simultaneous pop frees the slot and the push is accepted.
- Dropped push: fetch_valid_i & !flush_i & count==DEPTH & !pop.
  - The instruction is discarded and overflow_o is set to 1.
  - overflow_o stays 1 until reset or flush.
- Count update: count_next = count + push - pop. Push and pop together leave the count unchanged.
- Pointer update: wr_ptr increments on push, rd_ptr increments on pop.
- Latency: no bypass. An instruction pushed at edge N is visible on dec_* at edge N (registered), i.e. one cycle after fetch_valid_i. An empty queue never pops in the same cycle as the push.
- Outputs:
  - dec_valid_o = (count!=0).
  - dec_instr_o/dec_pc_o = array[rd_ptr] when valid, else 0.
- fetch_stall_o = ((DEPTH - count) <= SKID) | flush_i. Combinational from registered count, plus flush_i.
- Flush (flush_i=1 at an edge): count=0, rd_ptr=wr_ptr=0, overflow_o=0.
  - Incoming fetch_valid_i that cycle is discarded.
  - dec_ready_i is ignored that cycle (no pop counted).
  - dec_valid_o=0 from the next cycle.
- Flush has priority over push, pop and overflow.
- Fetch stall timing: fetch may deliver up to SKID further instructions after fetch_stall_o rises. With a correctly sized SKID, overflow_o never sets in normal operation; it is a verification/debug indicator only.

Test Plan:
- Reset, then push 3 instrs (pc 0x8000_0000/04/08, instr 0x0000_0013/0x0010_0093/0x0020_0113) with dec_ready_i=1 -> dec_valid_o rises one cycle after first push; same order on dec_*; count_o never exceeds 1; overflow_o=0.
- DEPTH=4, SKID=2, dec_ready_i=0, push 2 -> count_o=2, fetch_stall_o=1. Push 2 more -> count_o=4. Push a 5th -> dropped, overflow_o=1, head still pc 0x8000_0000.
- Full queue, push pc 0x8000_0010 and dec_ready_i=1 same cycle -> count_o stays 4, head advances to 0x8000_0004; pc 0x8000_0010 later emerges last; overflow_o=0.
- 3 entries queued, overflow_o=1, assert flush_i with fetch_valid_i=1 and dec_ready_i=1 -> next cycle count_o=0, dec_valid_o=0, overflow_o=0, fetch_stall_o=0 after flush_i drops.
- Wrap-around: stream 10 instrs, pc 0x8000_0000 + 4k, with dec_ready_i toggling every other cycle -> all 10 delivered in order, none duplicated or lost.
- Async reset asserted mid-cycle with count=3 -> dec_valid_o=0 and count_o=0 immediately, without waiting for a clock edge.
